// File: rtl/reg_file_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// reg_file_ctrl : valid/ready request controller for a 4x8 registered-read file
// Revision      : 1.0
// ============================================================================
module reg_file_ctrl #(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_is_wr_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic              rf_ce_o,
    output logic [DATA_W-1:0] rf_data_in_o,
    input  logic [DATA_W-1:0] rf_data_out_i
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_CAPT  = 2'd2;
    localparam logic [1:0] c_RSP   = 2'd3;

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_wr_q, is_wr_d;
    logic              err_q,   err_d;

    logic w_accept;
    logic w_addr_bad;

    assign req_ready_o  = (state_q == c_IDLE) && !rst_i;
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_addr_bad   = ({1'b0, req_addr_i} >= c_NUM_REGS);

    assign rsp_valid_o  = (state_q == c_RSP);
    assign rsp_rdata_o  = rdata_q;
    assign rsp_is_wr_o  = is_wr_q;
    assign rsp_err_o    = err_q;
    assign rf_addr_o    = addr_q;
    assign rf_data_in_o = wdata_q;
    assign rf_ce_o      = (state_q == c_ISSUE) && we_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    // Bad addresses never reach the file bus.
                    if (w_addr_bad) begin
                        state_d = c_RSP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        is_wr_d = req_we_i;
                    end else begin
                        state_d = c_ISSUE;
                        addr_d  = req_addr_i;
                        we_d    = req_we_i;
                        wdata_d = req_wdata_i;
                    end
                end
            end
            c_ISSUE: begin
                if (we_q) begin
                    state_d = c_RSP;
                    is_wr_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    state_d = c_CAPT;
                end
            end
            c_CAPT: begin
                state_d = c_RSP;
                rdata_d = rf_data_out_i;
                is_wr_d = 1'b0;
                err_d   = 1'b0;
            end
            c_RSP: begin
                if (rsp_ready_i) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_reg_file_ctrl : directed + randomized bench with transaction-level model
// Revision         : 1.0
// ============================================================================
module tb_reg_file_ctrl;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_is_wr;
    logic              rsp_err;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_ce;
    logic [DATA_W-1:0] rf_din;
    logic [DATA_W-1:0] rf_dout;
    logic              rf_rst_n;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    reg_file_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_is_wr_o(rsp_is_wr), .rsp_err_o(rsp_err),
        .rf_addr_o(rf_addr), .rf_ce_o(rf_ce), .rf_data_in_o(rf_din),
        .rf_data_out_i(rf_dout)
    );

    // Register file environment: registered read, init values 2..5, active-low reset.
    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    assign rf_rst_n = !rst;
    always_ff @(posedge clk or negedge rf_rst_n) begin
        if (!rf_rst_n) begin
            rf_mem[0] <= 8'd2;
            rf_mem[1] <= 8'd3;
            rf_mem[2] <= 8'd4;
            rf_mem[3] <= 8'd5;
            rf_dout   <= '0;
        end else begin
            if (rf_ce && rf_addr < 4'(NUM_REGS)) rf_mem[rf_addr[1:0]] <= rf_din;
            rf_dout <= (rf_addr < 4'(NUM_REGS)) ? rf_mem[rf_addr[1:0]] : '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: outstanding request, cycles since accept, expected response.
    bit          m_busy;
    int          m_cyc;
    int          m_lat;
    bit          m_wr;
    bit          m_err;
    logic [7:0]  m_rdata;
    logic [7:0]  m_wd;
    logic [3:0]  m_addr;
    logic [7:0]  m_mem [NUM_REGS];

    task automatic model_reset();
        m_busy = 1'b0;
        m_cyc  = 0;
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] = 8'(i + 2);
    endtask

    initial begin : compare_proc
        bit exp_valid;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                chk("reset_outputs", 32'({req_ready, rsp_valid, rsp_rdata, rsp_is_wr, rsp_err, rf_ce}), 32'd0);
                chk("reset_rf_bus", 32'({rf_addr, rf_din}), 32'd0);
            end else begin
                exp_valid = m_busy && (m_cyc >= m_lat);
                chk("req_ready", 32'(req_ready), 32'(!m_busy));
                chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
                chk("rf_ce", 32'(rf_ce), 32'(m_busy && m_cyc == 1 && m_wr && !m_err));
                if (exp_valid)
                    chk("rsp_fields", 32'({rsp_rdata, rsp_is_wr, rsp_err}), 32'({m_rdata, m_wr, m_err}));
                if (m_busy && !m_err && (m_cyc == 1 || (m_cyc == 2 && !m_wr)))
                    chk("rf_addr", 32'(rf_addr), 32'(m_addr));
                if (m_busy && !m_err && m_cyc == 1 && m_wr)
                    chk("rf_data_in", 32'(rf_din), 32'(m_wd));
                // Predict the effect of the upcoming rising edge.
                if (!m_busy) begin
                    if (req_valid) begin
                        m_busy  = 1'b1;
                        m_cyc   = 1;
                        m_wr    = req_we;
                        m_addr  = req_addr;
                        m_wd    = req_wdata;
                        m_err   = (req_addr >= 4'(NUM_REGS));
                        m_lat   = m_err ? 1 : (req_we ? 2 : 3);
                        m_rdata = (m_err || req_we) ? 8'd0 : m_mem[req_addr[1:0]];
                        if (!m_err && req_we) m_mem[req_addr[1:0]] = req_wdata;
                    end
                end else if (exp_valid && rsp_ready) begin
                    m_busy = 1'b0;
                end else begin
                    m_cyc++;
                end
            end
        end
    end

    // Directed transaction with literal expectations; entered and left at posedge+1.
    task automatic txn(input bit we, input logic [3:0] a, input logic [7:0] wd, input int hold,
                       input logic [7:0] er, input bit ee, input int elat);
        bit ok;
        int lat;
        req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = t; break; end
        end
        chk("rsp_latency", 32'(lat), 32'(elat));
        chk("rsp_rdata_lit", 32'(rsp_rdata), 32'(er));
        chk("rsp_err_lit", 32'(rsp_err), 32'(ee));
        chk("rsp_is_wr_lit", 32'(rsp_is_wr), 32'(we));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("held_valid", 32'(rsp_valid), 32'd1);
            chk("held_rdata", 32'(rsp_rdata), 32'(er));
            chk("held_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_retired", 32'(rsp_valid), 32'd0);
    endtask

    initial begin : stim_proc
        int acc1, acc2, lat;
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        txn(1'b0, 4'd0, 8'h00, 0, 8'd2, 1'b0, 3);
        txn(1'b0, 4'd1, 8'h00, 0, 8'd3, 1'b0, 3);
        txn(1'b0, 4'd2, 8'h00, 0, 8'd4, 1'b0, 3);
        txn(1'b0, 4'd3, 8'h00, 0, 8'd5, 1'b0, 3);
        txn(1'b1, 4'd2, 8'hA5, 0, 8'h00, 1'b0, 2);
        txn(1'b0, 4'd2, 8'h00, 0, 8'hA5, 1'b0, 3);
        txn(1'b0, 4'd1, 8'h00, 5, 8'd3, 1'b0, 3);
        txn(1'b0, 4'd7, 8'h00, 0, 8'h00, 1'b1, 1);
        txn(1'b1, 4'd4, 8'h11, 0, 8'h00, 1'b1, 1);
        txn(1'b0, 4'd0, 8'h00, 0, 8'd2, 1'b0, 3);

        // Reset while a read sits in CAPT.
        req_we = 1'b0; req_addr = 4'd1; req_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("rst_async_zero", 32'({rsp_valid, rf_ce, rf_addr, rf_din, rsp_rdata}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // Back-to-back write then read with valid held.
        req_we = 1'b1; req_addr = 4'd3; req_wdata = 8'h5A; req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        acc1 = cyc_cnt + 1;
        @(posedge clk); #1;
        req_we = 1'b0;
        acc2 = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready) begin acc2 = cyc_cnt + 1; break; end
        end
        chk("b2b_spacing", 32'(acc2 - acc1), 32'd3);
        @(posedge clk); #1 req_valid = 1'b0;
        ok = 1'b0; lat = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; lat = t; break; end
        end
        chk("b2b_rsp_timeout", 32'(ok), 32'd1);
        chk("b2b_latency", 32'(lat), 32'd3);
        chk("b2b_rdata", 32'(rsp_rdata), 32'h5A);
        @(posedge clk); #1;

        // Randomized traffic, back-pressure and occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            req_wdata = 8'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
